// File: rtl/sobel_filter_stream_if.sv
// Call/return and pixel-stream signals of sobel_filter_stream.
// The caller/producer side uses master, the filter uses slave.
interface sobel_filter_stream_if #(
    parameter int PIX_W = 8,
    parameter int COL_W = 10,
    parameter int ROW_W = 10
);
    logic             start;
    logic             busy;
    logic             done;
    logic             stall;
    logic [31:0]      returndata;
    logic [COL_W-1:0] cols;
    logic [ROW_W-1:0] rows;
    logic [1:0]       mode;
    logic [PIX_W-1:0] threshold;
    logic             in_valid;
    logic [PIX_W-1:0] in_data;
    logic             in_stall;
    logic             out_valid;
    logic [PIX_W-1:0] out_data;
    logic             out_stall;

    modport master (
        output start, stall, cols, rows, mode, threshold, in_valid, in_data, out_stall,
        input  busy, done, returndata, in_stall, out_valid, out_data
    );

    modport slave (
        input  start, stall, cols, rows, mode, threshold, in_valid, in_data, out_stall,
        output busy, done, returndata, in_stall, out_valid, out_data
    );
endinterface

// File: rtl/sobel_filter_stream.sv
// Streaming 3x3 Sobel filter with run-time image size. Two line buffers plus a
// 3x3 window feed a two-stage gradient/magnitude pipeline. One result per
// interior pixel; the call returns the number of results at or above threshold.
module sobel_filter_stream #(
    parameter int PIX_W    = 8,
    parameter int MAX_COLS = 640,
    parameter int COL_W    = 10,
    parameter int ROW_W    = 10
) (
    input logic                  clock,
    input logic                  reset,
    sobel_filter_stream_if.slave bus
);
    localparam int GW = PIX_W + 3;   // signed gradient width
    localparam int MW = PIX_W + 4;   // unsigned magnitude width
    localparam logic [PIX_W-1:0] PIX_MAX    = '1;
    localparam logic [COL_W-1:0] MAX_COLS_C = COL_W'(MAX_COLS);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic [31:0]      ret_q;
    logic [31:0]      hits;
    logic [COL_W-1:0] cols_q;
    logic [ROW_W-1:0] rows_q;
    logic [1:0]       mode_q;
    logic [PIX_W-1:0] thr_q;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic [PIX_W-1:0] lb0 [MAX_COLS];   // previous row
    logic [PIX_W-1:0] lb1 [MAX_COLS];   // row before that
    logic [PIX_W-1:0] wt0, wt1, wm0, wm1, wb0, wb1;   // window columns c-2 (0) and c-1 (1)

    logic signed [GW-1:0] gx_p1, gy_p1;
    logic                 vld_p1;
    logic [PIX_W-1:0]     out_p2;
    logic                 vld_p2;

    logic                 adv, accept, interior, legal;
    logic [PIX_W-1:0]     top_c, mid_c, bot_c;
    logic [GW-1:0]        right_s, left_s, lower_s, upper_s;
    logic signed [GW-1:0] gx_c, gy_c;
    logic [GW-1:0]        ax_c, ay_c;
    logic [MW-1:0]        mag_c;
    logic                 hit_c;
    logic [PIX_W-1:0]     res_c;

    function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] v);
        logic [GW-1:0] u;
        u = v;
        return v[GW-1] ? (~u + 1'b1) : u;
    endfunction

    function automatic logic [PIX_W-1:0] clamp_pix(input logic [MW-1:0] v);
        return (v > MW'(PIX_MAX)) ? PIX_MAX : v[PIX_W-1:0];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A full result register that cannot leave freezes the whole datapath.
    assign adv      = !(vld_p2 && bus.out_stall);
    assign accept   = (state == RUN) && bus.in_valid && adv;
    assign interior = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign legal    = (bus.cols >= COL_W'(3)) && (bus.cols <= MAX_COLS_C) &&
                      (bus.rows >= ROW_W'(3));

    assign bus.in_stall   = (state != RUN) || !adv;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.returndata = ret_q;
    assign bus.out_valid  = vld_p2;
    assign bus.out_data   = out_p2;

    // Newest window column comes straight from the line buffers and the input.
    assign top_c   = lb1[col];
    assign mid_c   = lb0[col];
    assign bot_c   = bus.in_data;
    assign right_s = GW'(top_c) + (GW'(mid_c) << 1) + GW'(bot_c);
    assign left_s  = GW'(wt0) + (GW'(wm0) << 1) + GW'(wb0);
    assign lower_s = GW'(wb0) + (GW'(wb1) << 1) + GW'(bot_c);
    assign upper_s = GW'(wt0) + (GW'(wt1) << 1) + GW'(top_c);
    assign gx_c    = $signed(right_s) - $signed(left_s);
    assign gy_c    = $signed(lower_s) - $signed(upper_s);

    // Magnitude, threshold and output mode selection for the stage-2 register.
    always_comb begin
        ax_c  = abs_g(gx_p1);
        ay_c  = abs_g(gy_p1);
        mag_c = MW'(ax_c) + MW'(ay_c);
        hit_c = (mag_c >= MW'(thr_q));
        case (mode_q)
            2'd0:    res_c = clamp_pix(mag_c);
            2'd1:    res_c = hit_c ? PIX_MAX : '0;
            2'd2:    res_c = clamp_pix(MW'(ax_c));
            default: res_c = clamp_pix(MW'(ay_c));
        endcase
    end

    // Call FSM, raster counters and saturating hit counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ret_q  <= '0;
            hits   <= '0;
            col    <= '0;
            row    <= '0;
        end else begin
            if (vld_p1 && adv && hit_c)
                hits <= sat_inc(hits);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cols_q <= bus.cols;
                        rows_q <= bus.rows;
                        mode_q <= bus.mode;
                        thr_q  <= bus.threshold;
                        col    <= '0;
                        row    <= '0;
                        hits   <= '0;
                        busy_q <= 1'b1;
                        if (legal) begin
                            state <= RUN;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            ret_q  <= 32'hFFFF_FFFF;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (col == cols_q - 1'b1) begin
                            col <= '0;
                            row <= row + 1'b1;
                            if (row == rows_q - 1'b1)
                                state <= FLUSH;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Last result leaving with nothing behind it in stage 1.
                    if (vld_p2 && !bus.out_stall && !vld_p1) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        ret_q  <= hits;
                    end
                end
                DONE: begin
                    if (!bus.stall) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line-buffer rotation and window shift on every accepted pixel.
    always_ff @(posedge clock) begin
        if (accept) begin
            lb0[col] <= bus.in_data;
            lb1[col] <= lb0[col];
            wt0 <= wt1;
            wt1 <= top_c;
            wm0 <= wm1;
            wm1 <= mid_c;
            wb0 <= wb1;
            wb1 <= bot_c;
        end
    end

    // Stage 1: signed gradients of the window completed by this pixel.
    always_ff @(posedge clock) begin
        if (adv) begin
            gx_p1 <= gx_c;
            gy_p1 <= gy_c;
        end
    end

    // Stage valids and stage 2 result register, all frozen under back-pressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            out_p2 <= '0;
        end else if (adv) begin
            vld_p1 <= interior;
            vld_p2 <= vld_p1;
            if (vld_p1)
                out_p2 <= res_c;
        end
    end
endmodule

// File: tb/tb_sobel_filter_stream.sv
// Bench for sobel_filter_stream: randomized frames against a plain-arithmetic
// Sobel model, with a scoreboard queue drained by an independent monitor.
module tb_sobel_filter_stream;
    localparam int PIX_W    = 8;
    localparam int MAX_COLS = 640;
    localparam int COL_W    = 10;
    localparam int ROW_W    = 10;

    logic clock;
    logic reset;

    sobel_filter_stream_if #(.PIX_W(PIX_W), .COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    sobel_filter_stream #(
        .PIX_W(PIX_W), .MAX_COLS(MAX_COLS), .COL_W(COL_W), .ROW_W(ROW_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int img [16][16];
    int exp_q [$];
    int stall_mode = 0;   // 0 none, 1 random, other: left to a task

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every result handed over must match the queue head.
    always @(negedge clock) begin
        if (bus.out_valid === 1'b1 && bus.out_stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0d required=none", bus.out_data);
            end else begin
                check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (stall_mode == 0)
            bus.out_stall = 1'b0;
        else if (stall_mode == 1)
            bus.out_stall = ($urandom_range(0, 2) == 0);
    end

    task automatic fill_const(input int c, input int r, input int v);
        for (int y = 0; y < r; y++)
            for (int x = 0; x < c; x++)
                img[y][x] = v;
    endtask

    task automatic fill_edge(input int r);
        for (int y = 0; y < r; y++) begin
            img[y][0] = 0; img[y][1] = 0; img[y][2] = 0; img[y][3] = 255; img[y][4] = 255;
        end
    endtask

    task automatic fill_rand(input int c, input int r);
        for (int y = 0; y < r; y++)
            for (int x = 0; x < c; x++)
                img[y][x] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255))
                          : (($urandom_range(0, 1) == 1) ? 255 : 0);
    endtask

    // Reference: textbook Sobel over every interior centre, in raster order.
    task automatic model(input int c, input int r, input int md, input int thr, output int hits);
        int gx, gy, ax, ay, mag, v;
        hits = 0;
        for (int y = 1; y < r - 1; y++) begin
            for (int x = 1; x < c - 1; x++) begin
                gx = (img[y-1][x+1] + 2 * img[y][x+1] + img[y+1][x+1])
                   - (img[y-1][x-1] + 2 * img[y][x-1] + img[y+1][x-1]);
                gy = (img[y+1][x-1] + 2 * img[y+1][x] + img[y+1][x+1])
                   - (img[y-1][x-1] + 2 * img[y-1][x] + img[y-1][x+1]);
                ax  = (gx < 0) ? -gx : gx;
                ay  = (gy < 0) ? -gy : gy;
                mag = ax + ay;
                case (md)
                    0:       v = (mag > 255) ? 255 : mag;
                    1:       v = (mag >= thr) ? 255 : 0;
                    2:       v = (ax > 255) ? 255 : ax;
                    default: v = (ay > 255) ? 255 : ay;
                endcase
                exp_q.push_back(v);
                if (mag >= thr)
                    hits++;
            end
        end
    endtask

    task automatic do_start(input int c, input int r, input int md, input int thr);
        @(posedge clock); #1;
        bus.start     = 1'b1;
        bus.cols      = COL_W'(c);
        bus.rows      = ROW_W'(r);
        bus.mode      = 2'(md);
        bus.threshold = PIX_W'(thr);
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic feed(input int c, input int n);
        int idx = 0;
        int guard = 0;
        logic acc;
        while (idx < n) begin
            bus.in_valid = ($urandom_range(0, 4) != 0);
            bus.in_data  = PIX_W'(img[idx / c][idx % c]);
            @(negedge clock);
            acc = bus.in_valid && !bus.in_stall;
            @(posedge clock); #1;
            if (acc)
                idx++;
            guard++;
            if (guard > 5000) begin
                checks++;
                errors++;
                $display("FAIL feed_timeout actual=%0d required=%0d", idx, n);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_call(input logic [31:0] exp_ret, input int hold);
        int got = 0;
        bus.stall = (hold > 0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                got = 1;
                break;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (got == 1) begin
            check("returndata", bus.returndata, exp_ret);
            check("busy_in_done", 32'(bus.busy), 32'd1);
            check("outputs_left", 32'(exp_q.size()), 32'd0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                check("done_hold", 32'(bus.done), 32'd1);
                check("ret_hold", bus.returndata, exp_ret);
            end
            bus.stall = 1'b0;
            @(negedge clock);
            check("done_clear", 32'(bus.done), 32'd0);
            check("busy_clear", 32'(bus.busy), 32'd0);
        end
        bus.stall = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_frame(input int c, input int r, input int md, input int thr, input int hold);
        int hits;
        model(c, r, md, thr, hits);
        do_start(c, r, md, thr);
        feed(c, c * r);
        finish_call(32'(hits), hold);
    endtask

    task automatic hold_test();
        int got = 0;
        logic [PIX_W-1:0] d;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clock); #1;
            if (bus.out_valid === 1'b1) begin
                got = 1;
                break;
            end
        end
        check("hold_found", 32'(got), 32'd1);
        if (got == 1) begin
            bus.out_stall = 1'b1;
            d = bus.out_data;
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                check("hold_data", 32'(bus.out_data), 32'(d));
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_in_stall", 32'(bus.in_stall), 32'd1);
            end
            @(posedge clock); #1;
            bus.out_stall = 1'b0;
        end
    endtask

    task automatic check_reset_values();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_returndata", bus.returndata, 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_in_stall", 32'(bus.in_stall), 32'd1);
    endtask

    initial begin
        int hits;
        bus.start = 1'b0; bus.stall = 1'b0; bus.cols = '0; bus.rows = '0;
        bus.mode = '0; bus.threshold = '0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.out_stall = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values();
        reset = 1'b0;

        // Flat image: four interior results, all zero.
        fill_const(4, 4, 100);
        run_frame(4, 4, 0, 1, 0);

        // Vertical edge in all four modes.
        fill_edge(3);
        run_frame(5, 3, 0, 128, 2);
        run_frame(5, 3, 1, 128, 0);
        run_frame(5, 3, 2, 128, 0);
        run_frame(5, 3, 3, 128, 0);

        // Forced output hold while pixels keep coming.
        stall_mode = 3;
        fill_rand(8, 6);
        model(8, 6, 0, 200, hits);
        do_start(8, 6, 0, 200);
        fork
            feed(8, 48);
            hold_test();
        join
        finish_call(32'(hits), 0);
        stall_mode = 0;

        // Random frames under random back-pressure, one per mode.
        stall_mode = 1;
        for (int k = 0; k < 4; k++) begin
            int c, r;
            c = $urandom_range(3, 12);
            r = $urandom_range(3, 10);
            fill_rand(c, r);
            run_frame(c, r, k, $urandom_range(0, 255), $urandom_range(0, 2));
        end
        stall_mode = 0;

        // Illegal configurations.
        do_start(2, 5, 0, 0);
        check("illegal_busy", 32'(bus.busy), 32'd1);
        finish_call(32'hFFFF_FFFF, 3);
        do_start(MAX_COLS + 1, 5, 0, 0);
        finish_call(32'hFFFF_FFFF, 0);
        do_start(5, 2, 0, 0);
        finish_call(32'hFFFF_FFFF, 0);

        // Reset part-way through a frame, then a clean frame with a stray start.
        fill_rand(5, 5);
        do_start(5, 5, 0, 50);
        feed(5, 7);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_values();
        reset = 1'b0;
        fill_rand(5, 5);
        model(5, 5, 1, 100, hits);
        do_start(5, 5, 1, 100);
        fork
            feed(5, 25);
            begin
                repeat (6) @(posedge clock);
                #1;
                bus.start = 1'b1;
                bus.cols  = COL_W'(3);
                bus.rows  = ROW_W'(3);
                bus.mode  = 2'd2;
                @(posedge clock); #1;
                bus.start = 1'b0;
            end
        join
        finish_call(32'(hits), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
